voice_allocator: RTL

- Sits between the MIDI/SPI front end and voice_controller.
- Accepts one note-on/note-off event at a time and maps each note to a voice slot: retrigger on a matching note, otherwise the lowest free slot, otherwise the oldest slot is stolen.
- Drives the voice_controller command interface (flag_dds, flag_adsr, voice_index, tuning_code, velocity, note_status) with single-cycle strobes.
- Also supports an all-notes-off (panic) sweep.

---
 rtl/voice_allocator.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Voice allocator: maps note-on/off events onto voice slots (retrigger, lowest free, oldest steal)
// and drives voice_controller command strobes; also provides an all-notes-off sweep.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int AGE_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ev_valid,
  output logic        o_ev_ready,
  input  logic        i_ev_note_on,
  input  logic [6:0]  i_ev_note,
  input  logic [6:0]  i_ev_velocity,
  input  logic [31:0] i_ev_tuning_code,
  input  logic        i_all_off,
  output logic        o_flag_dds,
  output logic        o_flag_adsr,
  output logic [7:0]  o_voice_index,
  output logic [31:0] o_tuning_code,
  output logic [6:0]  o_velocity,
  output logic        o_note_status,
  output logic        o_steal,
  output logic [8:0]  o_active_count
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, SWEEP} state_e;
  state_e state_q, state_d;

  logic             active_q [NUM_VOICES];
  logic [6:0]       note_q   [NUM_VOICES];
  logic [AGE_W-1:0] age_q    [NUM_VOICES];

  logic [IDX_W-1:0] idx_q;
  logic             panic_q;
  logic             ev_on_q;
  logic [6:0]       ev_note_q, ev_vel_q;
  logic [31:0]      ev_tc_q;

  logic             match_hit_q, match_hit_d, free_hit_q, free_hit_d, old_hit_q, old_hit_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;

  logic             flag_dds_q, flag_adsr_q, steal_q, status_q;
  logic [7:0]       vidx_q;
  logic [31:0]      tc_q;
  logic [6:0]       vel_q;
  logic [8:0]       count_q, count_d;

  logic             ev_ready, accept, sweep_start, scan_last, sweep_step;
  logic             do_on, do_off, do_steal, clr_en;
  logic [IDX_W-1:0] tgt_idx, clr_idx;
  logic             cur_active;
  logic [6:0]       cur_note;
  logic [AGE_W-1:0] cur_age;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state; a pending panic wins over a new event in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (panic_q) state_d = SWEEP;
               else if (i_ev_valid) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      SWEEP:   if (idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake is valid/ready, an event transfers on the cycle both are high
  always_comb begin
    ev_ready    = i_reset_n && (state_q == IDLE) && !panic_q;
    accept      = ev_ready && i_ev_valid;
    sweep_start = (state_q == IDLE) && panic_q;
    scan_last   = (state_q == SCAN) && (idx_q == LAST_IDX);
    sweep_step  = (state_q == SWEEP);
  end

  // Scan trackers folded with the slot currently under examination
  always_comb begin
    cur_active  = active_q[idx_q];
    cur_note    = note_q[idx_q];
    cur_age     = age_q[idx_q];
    match_hit_d = match_hit_q;
    match_idx_d = match_idx_q;
    free_hit_d  = free_hit_q;
    free_idx_d  = free_idx_q;
    old_hit_d   = old_hit_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    if (!match_hit_q && cur_active && (cur_note == ev_note_q)) begin
      match_hit_d = 1'b1;
      match_idx_d = idx_q;
    end
    if (!free_hit_q && !cur_active) begin
      free_hit_d = 1'b1;
      free_idx_d = idx_q;
    end
    if (cur_active && (!old_hit_q || (cur_age > old_age_q))) begin
      old_hit_d = 1'b1;
      old_idx_d = idx_q;
      old_age_d = cur_age;
    end
  end

  // Decision is taken on the last scan cycle so the strobes are registered into ISSUE
  always_comb begin
    do_on    = scan_last && ev_on_q;
    do_off   = scan_last && !ev_on_q && match_hit_d;
    do_steal = !match_hit_d && !free_hit_d;
    if (match_hit_d)     tgt_idx = match_idx_d;
    else if (free_hit_d) tgt_idx = free_idx_d;
    else                 tgt_idx = old_idx_d;
    clr_en  = do_off || (sweep_step && active_q[idx_q]);
    clr_idx = sweep_step ? idx_q : tgt_idx;
    count_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) count_d = count_d + 9'(active_q[i]);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q       <= '0;
      panic_q     <= 1'b0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      ev_vel_q    <= '0;
      ev_tc_q     <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
      old_hit_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      count_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        active_q[i] <= 1'b0;
        note_q[i]   <= '0;
        age_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      panic_q <= sweep_start ? i_all_off : (panic_q | i_all_off);
      if (accept || sweep_start)                   idx_q <= '0;
      else if (state_q == SCAN || state_q == SWEEP) idx_q <= idx_q + IDX_W'(1);
      if (accept) begin
        ev_on_q     <= i_ev_note_on;
        ev_note_q   <= i_ev_note;
        ev_vel_q    <= i_ev_velocity;
        ev_tc_q     <= i_ev_tuning_code;
        match_hit_q <= 1'b0;
        free_hit_q  <= 1'b0;
        old_hit_q   <= 1'b0;
        old_age_q   <= '0;
      end else if (state_q == SCAN) begin
        match_hit_q <= match_hit_d;
        match_idx_q <= match_idx_d;
        free_hit_q  <= free_hit_d;
        free_idx_q  <= free_idx_d;
        old_hit_q   <= old_hit_d;
        old_idx_q   <= old_idx_d;
        old_age_q   <= old_age_d;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (do_on) begin
          if (IDX_W'(i) == tgt_idx) begin
            active_q[i] <= 1'b1;
            note_q[i]   <= ev_note_q;
            age_q[i]    <= '0;
          end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
            age_q[i] <= age_q[i] + AGE_W'(1);
          end
        end else if (clr_en && (IDX_W'(i) == clr_idx)) begin
          active_q[i] <= 1'b0;
        end
      end
    end
  end

  // Command outputs: strobes are single-cycle, data holds until the next command
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      flag_dds_q  <= 1'b0;
      flag_adsr_q <= 1'b0;
      steal_q     <= 1'b0;
      status_q    <= 1'b0;
      vidx_q      <= '0;
      tc_q        <= '0;
      vel_q       <= '0;
    end else begin
      flag_dds_q  <= 1'b0;
      flag_adsr_q <= 1'b0;
      steal_q     <= 1'b0;
      if (do_on) begin
        flag_dds_q  <= 1'b1;
        flag_adsr_q <= 1'b1;
        steal_q     <= do_steal;
        status_q    <= 1'b1;
        vidx_q      <= 8'(tgt_idx);
        tc_q        <= ev_tc_q;
        vel_q       <= ev_vel_q;
      end else if (clr_en) begin
        flag_adsr_q <= 1'b1;
        status_q    <= 1'b0;
        vidx_q      <= 8'(clr_idx);
      end
    end
  end

  assign o_ev_ready     = ev_ready;
  assign o_flag_dds     = flag_dds_q;
  assign o_flag_adsr    = flag_adsr_q;
  assign o_steal        = steal_q;
  assign o_note_status  = status_q;
  assign o_voice_index  = vidx_q;
  assign o_tuning_code  = tc_q;
  assign o_velocity     = vel_q;
  assign o_active_count = count_q;

endmodule
